scsp_ram_arbiter: RTL and testbench

// Shares the single 16-bit sound RAM port between four requesters: SCSP slot wavetable fetch,

---
 rtl/scsp_ram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_scsp_ram_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scsp_ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : scsp_ram_arbiter
// Description : Shares the single 16-bit sound RAM port between the SCSP slot
//               fetch, SCSP DSP, sound CPU and host requesters. Slot and DSP
//               have fixed priority; CPU and host alternate round-robin. A
//               starvation counter forces a CPU/host grant after STARVE_MAX
//               consecutive slot/DSP grants.
// Revision    : 1.0 - initial release
// ============================================================================
module scsp_ram_arbiter #(
  parameter int AW         = 18,
  parameter int STARVE_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ce,
  input  logic          i_slot_req,
  input  logic          i_dsp_req,
  input  logic          i_cpu_req,
  input  logic          i_host_req,
  input  logic [AW:1]   i_slot_a,
  input  logic [AW:1]   i_dsp_a,
  input  logic [AW:1]   i_cpu_a,
  input  logic [AW:1]   i_host_a,
  input  logic [15:0]   i_dsp_d,
  input  logic [15:0]   i_cpu_d,
  input  logic [15:0]   i_host_d,
  input  logic [1:0]    i_dsp_we,
  input  logic [1:0]    i_cpu_we,
  input  logic [1:0]    i_host_we,
  output logic          o_slot_ack,
  output logic          o_dsp_ack,
  output logic          o_cpu_ack,
  output logic          o_host_ack,
  output logic [15:0]   o_rd_q,
  output logic [AW:1]   o_ram_a,
  output logic [15:0]   o_ram_d,
  output logic [1:0]    o_ram_we,
  output logic          o_ram_rd,
  output logic          o_ram_cs,
  input  logic [15:0]   i_ram_q,
  input  logic          i_ram_rdy
);

  localparam logic [1:0] C_P_SLOT = 2'd0;
  localparam logic [1:0] C_P_DSP  = 2'd1;
  localparam logic [1:0] C_P_CPU  = 2'd2;
  localparam logic [1:0] C_P_HOST = 2'd3;
  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t        r_state;
  logic [1:0]    r_port;     // latched winner of the current access
  logic          r_rr;       // 0 = CPU next, 1 = host next
  logic [3:0]    r_starve;
  logic [3:0]    r_ack;      // {host, cpu, dsp, slot}
  logic [15:0]   r_rd_q;
  logic [AW:1]   r_ram_a;
  logic [15:0]   r_ram_d;
  logic [1:0]    r_ram_we;
  logic          r_ram_rd;
  logic          r_ram_cs;

  logic [3:0]    w_el;
  logic          w_ch_any;
  logic          w_ch_pend;
  logic [1:0]    w_ch_win;
  logic          w_starved;
  logic          w_any;
  logic [1:0]    w_win;
  logic [AW:1]   w_a;
  logic [15:0]   w_d;
  logic [1:0]    w_we;

  // Arbitration: eligibility masking, CPU/host round-robin, starvation override
  always_comb begin
    w_el[0]   = i_slot_req & ~r_ack[0];
    w_el[1]   = i_dsp_req  & ~r_ack[1];
    w_el[2]   = i_cpu_req  & ~r_ack[2];
    w_el[3]   = i_host_req & ~r_ack[3];
    w_ch_any  = w_el[2] | w_el[3];
    w_ch_pend = i_cpu_req | i_host_req;
    w_any     = |w_el;
    if (w_el[2] && w_el[3]) begin
      w_ch_win = r_rr ? C_P_HOST : C_P_CPU;
    end else if (w_el[2]) begin
      w_ch_win = C_P_CPU;
    end else begin
      w_ch_win = C_P_HOST;
    end
    w_starved = (r_starve == C_STARVE_MAX) && w_ch_any;
    if (w_starved) begin
      w_win = w_ch_win;
    end else if (w_el[0]) begin
      w_win = C_P_SLOT;
    end else if (w_el[1]) begin
      w_win = C_P_DSP;
    end else begin
      w_win = w_ch_win;
    end
    case (w_win)
      C_P_SLOT: begin w_a = i_slot_a; w_d = 16'h0000;  w_we = 2'b00;     end
      C_P_DSP:  begin w_a = i_dsp_a;  w_d = i_dsp_d;   w_we = i_dsp_we;  end
      C_P_CPU:  begin w_a = i_cpu_a;  w_d = i_cpu_d;   w_we = i_cpu_we;  end
      default:  begin w_a = i_host_a; w_d = i_host_d;  w_we = i_host_we; end
    endcase
  end

  // Access FSM with registered RAM-side and requester-side outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_port   <= C_P_SLOT;
      r_rr     <= 1'b0;
      r_starve <= 4'd0;
      r_ack    <= 4'b0000;
      r_rd_q   <= 16'h0000;
      r_ram_a  <= '0;
      r_ram_d  <= 16'h0000;
      r_ram_we <= 2'b00;
      r_ram_rd <= 1'b0;
      r_ram_cs <= 1'b0;
    end else begin
      // ACK is a single-cycle pulse regardless of CE
      r_ack <= 4'b0000;
      if (i_ce) begin
        case (r_state)
          ST_IDLE: begin
            if (w_any) begin
              r_state  <= ST_ACCESS;
              r_port   <= w_win;
              r_ram_cs <= 1'b1;
              r_ram_a  <= w_a;
              r_ram_d  <= w_d;
              r_ram_we <= w_we;
              r_ram_rd <= (w_we == 2'b00);
            end
          end
          ST_ACCESS: begin
            if (i_ram_rdy) begin
              r_state        <= ST_IDLE;
              r_ram_cs       <= 1'b0;
              r_ram_rd       <= 1'b0;
              r_ram_we       <= 2'b00;
              r_ack[r_port]  <= 1'b1;
              if (r_ram_rd) begin
                r_rd_q <= i_ram_q;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase

        // Starvation counter and round-robin pointer bookkeeping
        if ((r_state == ST_IDLE) && w_any && w_win[1]) begin
          r_starve <= 4'd0;
          r_rr     <= (w_win == C_P_CPU);
        end else if ((r_state == ST_IDLE) && w_any && w_ch_pend) begin
          if (r_starve != C_STARVE_MAX) begin
            r_starve <= r_starve + 4'd1;
          end
        end else if (!w_ch_pend) begin
          r_starve <= 4'd0;
        end
      end
    end
  end

  assign o_slot_ack = r_ack[0];
  assign o_dsp_ack  = r_ack[1];
  assign o_cpu_ack  = r_ack[2];
  assign o_host_ack = r_ack[3];
  assign o_rd_q     = r_rd_q;
  assign o_ram_a    = r_ram_a;
  assign o_ram_d    = r_ram_d;
  assign o_ram_we   = r_ram_we;
  assign o_ram_rd   = r_ram_rd;
  assign o_ram_cs   = r_ram_cs;

endmodule
`default_nettype wire

// File: tb/tb_scsp_ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_scsp_ram_arbiter
// Description : Scoreboard bench for scsp_ram_arbiter. Requester processes
//               push expected responses from a flat memory model; a monitor
//               pops and compares on every ACK. Directed sequences check
//               latency, priority order, round-robin, starvation, RDY stalls,
//               reset abort and CE freeze; a random phase follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scsp_ram_arbiter;
  localparam int AW = 18;
  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic [AW:1] addr;
    logic [1:0]  we;
    logic [15:0] data;
  } cmd_t;

  typedef struct packed {
    logic        is_rd;
    logic [AW:1] addr;
    logic [1:0]  we;
    logic [15:0] data;
    logic [15:0] exp;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [3:0]    req;
  logic [AW:1]   a  [4];
  logic [15:0]   d  [4];
  logic [1:0]    we [4];
  logic [3:0]    ack;
  logic [15:0]   rd_q;
  logic [AW:1]   ram_a;
  logic [15:0]   ram_d;
  logic [1:0]    ram_we;
  logic          ram_rd;
  logic          ram_cs;
  logic [15:0]   ram_q;
  logic          ram_rdy;

  int   checks = 0;
  int   errors = 0;
  int   mode = 0;          // 0 = manual CE/RDY, 1 = random CE/RDY
  logic man_ce = 1'b1;
  logic man_rdy = 1'b1;
  bit   order_en = 1'b0;
  int   exp_order[$];
  cmd_t cmd_q [4][$];
  exp_t sb_q  [4][$];
  logic [15:0] model_mem [int];
  logic [15:0] ram_mem   [int];

  scsp_ram_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .i_slot_req(req[0]), .i_dsp_req(req[1]), .i_cpu_req(req[2]), .i_host_req(req[3]),
    .i_slot_a(a[0]), .i_dsp_a(a[1]), .i_cpu_a(a[2]), .i_host_a(a[3]),
    .i_dsp_d(d[1]), .i_cpu_d(d[2]), .i_host_d(d[3]),
    .i_dsp_we(we[1]), .i_cpu_we(we[2]), .i_host_we(we[3]),
    .o_slot_ack(ack[0]), .o_dsp_ack(ack[1]), .o_cpu_ack(ack[2]), .o_host_ack(ack[3]),
    .o_rd_q(rd_q), .o_ram_a(ram_a), .o_ram_d(ram_d), .o_ram_we(ram_we),
    .o_ram_rd(ram_rd), .o_ram_cs(ram_cs), .i_ram_q(ram_q), .i_ram_rdy(ram_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [AW:1] ad);
    return ad[16:1] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] w,
                                        input logic [15:0] nd);
    return {w[1] ? nd[15:8] : old[15:8], w[0] ? nd[7:0] : old[7:0]};
  endfunction

  function automatic logic [15:0] model_rd(input logic [AW:1] ad);
    if (model_mem.exists(int'(ad))) return model_mem[int'(ad)];
    return init_val(ad);
  endfunction

  function automatic logic [15:0] ram_read(input logic [AW:1] ad);
    if (ram_mem.exists(int'(ad))) return ram_mem[int'(ad)];
    return init_val(ad);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // One requester: issues queued commands, holds REQ through ACK, renews or drops
  task automatic requester(input int p);
    cmd_t c;
    exp_t e;
    int   n;
    int   gap;
    gap = 0;
    forever begin
      @(posedge clk); #1;
      if (gap > 0) begin
        gap--;
        req[p] = 1'b0;
      end else if (cmd_q[p].size() > 0) begin
        c = cmd_q[p].pop_front();
        e.is_rd = (c.we == 2'b00);
        e.addr  = c.addr;
        e.we    = c.we;
        e.data  = c.data;
        if (e.is_rd) begin
          e.exp = model_rd(c.addr);
        end else begin
          e.exp = 16'h0000;
          model_mem[int'(c.addr)] = merge(model_rd(c.addr), c.we, c.data);
        end
        sb_q[p].push_back(e);
        a[p] = c.addr; d[p] = c.data; we[p] = c.we; req[p] = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!ack[p] && n < 5000);
        if (!ack[p]) begin
          checks++; errors++;
          $display("FAIL ack_timeout: port %0d got no ACK expected ACK within 5000 cycles", p);
          req[p] = 1'b0;
        end
        if (mode == 1) gap = $urandom_range(0, 2);
      end else begin
        req[p] = 1'b0;
      end
    end
  endtask

  initial begin
    fork
      requester(0);
      requester(1);
      requester(2);
      requester(3);
    join_none
  end

  // RAM environment: read data follows RAM_A, CE/RDY manual or random
  initial begin
    ce = 1'b1; ram_rdy = 1'b1; ram_q = 16'h0000;
    forever begin
      @(posedge clk); #2;
      ram_q = ram_read(ram_a);
      if (mode == 1) begin
        ram_rdy = ($urandom_range(0, 3) != 0);
        ce      = ($urandom_range(0, 7) != 0);
      end else begin
        ram_rdy = man_rdy;
        ce      = man_ce;
      end
    end
  end

  // Monitor: ACK scoreboard, ordering, RAM request legality, RAM writes
  initial begin
    exp_t e;
    int   nack;
    bit   found;
    forever begin
      @(negedge clk);
      if (!rst) begin
        nack = $countones(ack);
        if (nack > 0) chk("single_ack", nack, 1);
        for (int p = 0; p < 4; p++) begin
          if (ack[p]) begin
            checks++;
            if (sb_q[p].size() == 0) begin
              errors++;
              $display("FAIL unexpected_ack: port %0d got ACK expected none", p);
            end else begin
              e = sb_q[p].pop_front();
              if (e.is_rd) chk($sformatf("rd_q_port%0d", p), rd_q, e.exp);
            end
            if (order_en) begin
              if (exp_order.size() == 0) begin
                checks++; errors++;
                $display("FAIL ack_order: got port %0d expected no further ACK", p);
              end else begin
                chk("ack_order", p, exp_order.pop_front());
              end
            end
          end
        end
        if (ram_we != 2'b00) chk("we_only_in_access", ram_cs, 1);
        if (ram_cs && ram_rdy && ce) begin
          found = 1'b0;
          for (int p = 0; p < 4; p++) begin
            if (sb_q[p].size() > 0) begin
              e = sb_q[p][0];
              if (e.addr == ram_a && e.we == ram_we && ram_rd == e.is_rd &&
                  (e.is_rd || e.data == ram_d)) found = 1'b1;
            end
          end
          chk("ram_request", found, 1);
          if (ram_we != 2'b00)
            ram_mem[int'(ram_a)] = merge(ram_read(ram_a), ram_we, ram_d);
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int  n;
    bit  idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      @(negedge clk);
      n++;
      idle = (req == 4'b0000);
      for (int p = 0; p < 4; p++)
        if (cmd_q[p].size() != 0 || sb_q[p].size() != 0) idle = 1'b0;
    end
    chk("idle_reached", idle, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic cmd_t mk(input int p, input logic [1:0] w, input logic [15:0] dd);
    cmd_t c;
    c.addr = {2'(p), 12'h000, 4'($urandom_range(0, 15))};
    c.we   = (p == 0) ? 2'b00 : w;
    c.data = dd;
    return c;
  endfunction

  initial begin
    cmd_t c;
    int   ordr[$];
    rst = 1'b1; req = 4'b0000;
    for (int p = 0; p < 4; p++) begin a[p] = '0; d[p] = '0; we[p] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", ram_cs, 0); chk("rst_rd", ram_rd, 0); chk("rst_we", ram_we, 0);
    chk("rst_a", ram_a, 0); chk("rst_d", ram_d, 0); chk("rst_rdq", rd_q, 0);
    chk("rst_ack", ack, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single CPU read latency
    model_mem[int'(18'h00100)] = 16'h1234;
    ram_mem[int'(18'h00100)]   = 16'h1234;
    @(negedge clk);
    c.addr = 18'h00100; c.we = 2'b00; c.data = 16'h0;
    cmd_q[2].push_back(c);
    @(negedge clk); chk("lat_c0_cs", ram_cs, 0);
    @(negedge clk); chk("lat_c1_cs", ram_cs, 1); chk("lat_c1_rd", ram_rd, 1);
    chk("lat_c1_a", ram_a, 18'h00100);
    @(negedge clk); chk("lat_c2_ack", ack[2], 1); chk("lat_c2_rdq", rd_q, 16'h1234);
    chk("lat_c2_cs", ram_cs, 0);
    wait_idle(100);

    // All four together: fixed priority then round-robin
    do_reset();
    order_en = 1'b1;
    ordr = '{0, 1, 2, 3};
    exp_order = ordr;
    @(negedge clk);
    for (int p = 0; p < 4; p++) cmd_q[p].push_back(mk(p, 2'($urandom_range(0, 3)), 16'($urandom)));
    wait_idle(200);
    chk("order2_drained", exp_order.size(), 0);

    // CPU and host held: strict alternation
    ordr = '{2, 3, 2, 3, 2, 3, 2, 3};
    exp_order = ordr;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      cmd_q[2].push_back(mk(2, 2'($urandom_range(0, 3)), 16'($urandom)));
      cmd_q[3].push_back(mk(3, 2'($urandom_range(0, 3)), 16'($urandom)));
    end
    wait_idle(300);
    chk("order3_drained", exp_order.size(), 0);

    // Slot/DSP saturating the port starve the CPU for exactly STARVE_MAX grants
    ordr = '{0, 1, 0, 1, 2, 0, 1, 0, 1};
    exp_order = ordr;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      cmd_q[0].push_back(mk(0, 2'b00, 16'h0));
      cmd_q[1].push_back(mk(1, 2'($urandom_range(0, 3)), 16'($urandom)));
    end
    cmd_q[2].push_back(mk(2, 2'b00, 16'h0));
    wait_idle(300);
    chk("order4_drained", exp_order.size(), 0);
    order_en = 1'b0;

    // DSP upper-byte write with three RDY wait cycles
    @(posedge clk); #1 man_rdy = 1'b0;
    @(negedge clk);
    c.addr = 18'h10042; c.we = 2'b10; c.data = 16'hABCD;
    cmd_q[1].push_back(c);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1 man_rdy = (i == 4);
      @(negedge clk);
      chk("stall_cs", ram_cs, 1); chk("stall_we", ram_we, 2'b10);
      chk("stall_d", ram_d, 16'hABCD); chk("stall_noack", ack[1], 0);
    end
    @(negedge clk);
    chk("stall_ack", ack[1], 1); chk("stall_cs_drop", ram_cs, 0); chk("stall_we_drop", ram_we, 0);
    wait_idle(100);

    // Reset during an access aborts it; the held request is served afterwards
    @(posedge clk); #1 man_rdy = 1'b0;
    @(negedge clk);
    cmd_q[2].push_back(mk(2, 2'b00, 16'h0));
    @(negedge clk);
    @(negedge clk); chk("rstab_cs_before", ram_cs, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("rstab_cs", ram_cs, 0); chk("rstab_ack", ack, 0);
    @(posedge clk); #1 rst = 1'b0; man_rdy = 1'b1;
    wait_idle(100);

    // CE low for five cycles in ACCESS freezes everything
    @(negedge clk);
    c = mk(3, 2'b00, 16'h0);
    cmd_q[3].push_back(c);
    @(negedge clk);
    @(posedge clk); #1 man_ce = 1'b0;
    @(negedge clk); chk("ce_c1_cs", ram_cs, 1);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      chk("ce_frozen_cs", ram_cs, 1); chk("ce_frozen_ack", ack[3], 0);
      chk("ce_frozen_a", ram_a, c.addr);
    end
    @(posedge clk); #1 man_ce = 1'b1;
    @(negedge clk); chk("ce_c6_noack", ack[3], 0);
    @(negedge clk); chk("ce_c7_ack", ack[3], 1);
    wait_idle(100);

    // Random traffic with random CE and RDY
    mode = 1;
    for (int k = 0; k < 25; k++)
      for (int p = 0; p < 4; p++)
        cmd_q[p].push_back(mk(p, 2'($urandom_range(0, 3)), 16'($urandom)));
    wait_idle(20000);
    mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 900us");
    $fatal(1);
  end

endmodule
`default_nettype wire
